uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART serial transmitter and the counterpart of uart_rx in the same UART block.
- Accepts a parallel byte through a valid/ready handshake and serialises it on tx_o.
- Frame: start bit, DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits.
- Bit timing is a fixed clock count per bit, and defaults match uart_rx (10 clocks/bit) so the two loop back directly.

Parameters:
CLKS_PER_BIT, 10, clock cycles per serial bit (>=2)
DATA_BITS, 8, data bits per frame (5..8)
PARITY_EN, 0, 1 = insert parity bit after data
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (only when PARITY_EN=1)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
data_i  input  DATA_BITS  byte to send, sampled only on acceptance
tx_start_i  input  1  request to send data_i (valid)
tx_ready_o  output  1  high when a new byte can be accepted
tx_o  output  1  serial line, idle high, registered
tx_busy_o  output  1  high while a frame is in progress
tx_done_o  output  1  one-cycle pulse when a frame completes

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset values: tx_o=1, tx_ready_o=1, tx_busy_o=0, tx_done_o=0, state=IDLE, counters=0, shift register=0.
- States: IDLE, START, DATA, PARITY, STOP.
- tx_ready_o = (state==IDLE). tx_busy_o = !tx_ready_o. Both are registered.
- Acceptance occurs at the edge where tx_start_i && tx_ready_o.
  - data_i is latched into the shift register.
  - Parity is computed from the latched byte: even = XOR of bits; odd = inverted XOR.
  - state goes to START and tx_o goes to 0 from the next cycle.
- Bit timing:
  - Each state holds tx_o for exactly CLKS_PER_BIT cycles, counted by a bit timer that counts 0..CLKS_PER_BIT-1.
  - At terminal count the next bit is presented on the following cycle.
- State transitions and line values:
  - START: tx_o=0, then DATA.
  - DATA: tx_o = shift[0]; shift right at each bit end. After DATA_BITS bits, go to PARITY if PARITY_EN, else STOP.
  - PARITY: tx_o = parity bit, then STOP.
  - STOP: tx_o=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
- Frame length from first start cycle to last stop cycle: (1+DATA_BITS+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
- tx_done_o is high for exactly one cycle: the first IDLE cycle after the final stop cycle. tx_ready_o is already high in that cycle.
- Back-to-back frames:
  - A tx_start_i in the done cycle is accepted.
  - The next start bit begins on the following cycle, so the minimum idle gap between frames is 1 cycle (tx_o=1).
- tx_start_i while busy is ignored; there is no queueing. data_i changes during a frame have no effect.
- Reset mid-frame: on the next cycle tx_o=1 and state=IDLE. The frame is truncated with no tx_done_o pulse.
- Reset has priority over tx_start_i in the same cycle.
- tx_o is driven straight from a flop, giving a glitch-free line.

Decomposition:
- Shared include uart_defs.vh holds:
  - state encodings (IDLE..STOP, 3 bits)
  - default CLKS_PER_BIT=10, shared with uart_rx
  - UART_IDLE_LEVEL=1
- One sub-module, uart_bit_timer:
  - inputs: clk, rst, clear, en
  - output: bit_end pulse at count CLKS_PER_BIT-1
  - parameter: CLKS_PER_BIT
  - reusable by uart_rx
- FSM, shift register and parity stay in uart_tx.

Test Plan:
- Default params, data_i=0x55 accepted at cycle T -> tx_o=0 on T+1..T+10; data bits 1,0,1,0,1,0,1,0 each for 10 cycles (T+11..T+90); tx_o=1 on T+91..T+100; tx_done_o=1 only at T+101; tx_busy_o high T+1..T+100.
- Loopback tx_o->uart_rx.rx_i, send 0xA3 then 0x00 then 0xFF -> uart_rx data_o equals each byte with one rx_done_o pulse per frame; tx_done_o count=3.
- PARITY_EN=1, PARITY_ODD=0, data 0x07 -> parity bit=1 in cycles T+91..T+100, stop T+101..T+110. With PARITY_ODD=1 -> parity bit=0.
- Back-to-back: hold tx_start_i=1 with 0x12 then 0x34 -> second start bit begins the cycle after the first tx_done_o; exactly one idle-high cycle between frames; both bytes correct.
- tx_start_i pulsed with 0xEE at T+40 during a 0x55 frame -> ignored; waveform identical to the 0x55 case; no extra frame.
- rst=1 for 1 cycle at T+50 mid-frame -> tx_o=1, tx_ready_o=1 from T+51; no tx_done_o; a new 0x5A sent afterwards is correct. STOP_BITS=2 run -> stop high for 20 cycles.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing and line idle level.
// Also used by uart_rx, so the two ends agree on timing and levels.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   localparam int   UART_CLKS_PER_BIT_DEF = 10;
   localparam logic UART_IDLE_LEVEL       = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and pulses bit_end on the last count.
// Also used by uart_rx.
module uart_bit_timer import uart_tx_pkg::*; #(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic bit_end
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign bit_end = en && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits.
// All outputs come straight from flops; tx_o is computed from the next state so the line never glitches.
//
// state     | meaning
// ST_IDLE   | line high, ready for a byte
// ST_START  | start bit (low)
// ST_DATA   | data bits, LSB first
// ST_PARITY | parity bit (PARITY_EN only)
// ST_STOP   | stop bit(s) high
module uart_tx import uart_tx_pkg::*; #(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] data_i,
   input  logic                 tx_start_i,
   output logic                 tx_ready_o,
   output logic                 tx_o,
   output logic                 tx_busy_o,
   output logic                 tx_done_o
);

   uart_state_e          state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 accept;
   logic                 bit_end;

   assign accept = (state_q == ST_IDLE) && tx_start_i;

   uart_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (accept),
      .en      (state_q != ST_IDLE),
      .bit_end (bit_end)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      par_d     = par_q;
      tx_d      = tx_q;
      done_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            tx_d = UART_IDLE_LEVEL;
            if (accept) begin
               shift_d   = data_i;
               par_d     = (^data_i) ^ (PARITY_ODD != 0);
               bit_cnt_d = '0;
               state_d   = ST_START;
               tx_d      = ~UART_IDLE_LEVEL;
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_d = ST_DATA;
               tx_d    = shift_q[0];
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                  bit_cnt_d = '0;
                  if (PARITY_EN != 0) begin
                     state_d = ST_PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = ST_STOP;
                     tx_d    = UART_IDLE_LEVEL;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  tx_d      = shift_q[1];
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               state_d = ST_STOP;
               tx_d    = UART_IDLE_LEVEL;
            end
         end
         ST_STOP: begin
            tx_d = UART_IDLE_LEVEL;
            if (bit_end) begin
               if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = ST_IDLE;
                  done_d    = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = UART_IDLE_LEVEL;
         end
      endcase
      ready_d = (state_d == ST_IDLE);
      busy_d  = ~ready_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         par_q     <= 1'b0;
         tx_q      <= UART_IDLE_LEVEL;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         par_q     <= par_d;
         tx_q      <= tx_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign tx_o       = tx_q;
   assign tx_ready_o = ready_q;
   assign tx_busy_o  = busy_q;
   assign tx_done_o  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (default, even parity + 2 stop bits, odd parity)
// compared cycle by cycle against an independently built frame model.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data;
   logic       start0, start1, start2;
   logic       tx0, rdy0, busy0, done0;
   logic       tx1, rdy1, busy1, done1;
   logic       tx2, rdy2, busy2, done2;

   int vecs = 0;
   int errs = 0;
   int sel  = 0;

   logic m_tx, m_rdy, m_busy, m_done;
   logic cap_tx   [0:255];
   logic cap_rdy  [0:255];
   logic cap_busy [0:255];
   logic cap_done [0:255];

   always #5 clk = ~clk;

   uart_tx u_dut0 (
      .clk(clk), .rst(rst), .data_i(data), .tx_start_i(start0),
      .tx_ready_o(rdy0), .tx_o(tx0), .tx_busy_o(busy0), .tx_done_o(done0));

   uart_tx #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut1 (
      .clk(clk), .rst(rst), .data_i(data), .tx_start_i(start1),
      .tx_ready_o(rdy1), .tx_o(tx1), .tx_busy_o(busy1), .tx_done_o(done1));

   uart_tx #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
      .clk(clk), .rst(rst), .data_i(data), .tx_start_i(start2),
      .tx_ready_o(rdy2), .tx_o(tx2), .tx_busy_o(busy2), .tx_done_o(done2));

   always_comb begin
      m_tx = tx0; m_rdy = rdy0; m_busy = busy0; m_done = done0;
      case (sel)
         1: begin m_tx = tx1; m_rdy = rdy1; m_busy = busy1; m_done = done1; end
         2: begin m_tx = tx2; m_rdy = rdy2; m_busy = busy2; m_done = done2; end
         default: ;
      endcase
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_start(input int w, input logic v);
      case (w)
         1:       start1 = v;
         2:       start2 = v;
         default: start0 = v;
      endcase
   endtask

   // Expected line level k cycles after the accepting edge (k=1 is the first start-bit cycle).
   function automatic logic exp_bit(input logic [7:0] d, input int pen, input logic podd,
                                    input int nstop, input int k);
      int idx = (k - 1) / 10;
      int len = 1 + 8 + pen + nstop;
      if (k < 1 || idx >= len) return 1'b1;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return d[idx-1];
      if (pen != 0 && idx == 9) return (^d) ^ podd;
      return 1'b1;
   endfunction

   // Accept d on instance w, then capture n cycles. Optional start pulse at inj_at, reset at rst_at.
   task automatic run(input int w, input logic [7:0] d, input int n,
                      input int inj_at, input logic [7:0] inj_d, input int rst_at);
      sel  = w;
      data = d;
      set_start(w, 1'b1);
      tick;
      set_start(w, 1'b0);
      data = 8'hC3;
      for (int k = 1; k <= n; k++) begin
         cap_tx[k] = m_tx; cap_rdy[k] = m_rdy; cap_busy[k] = m_busy; cap_done[k] = m_done;
         if (k == inj_at) begin data = inj_d; set_start(w, 1'b1); end
         if (k == rst_at) rst = 1'b1;
         tick;
         set_start(w, 1'b0);
         rst = 1'b0;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; data = 8'h00;
      repeat (3) tick;
      vecs++; if ({tx0, rdy0, busy0, done0} !== 4'b1100) begin
         errs++; $display("FAIL reset_dut0 got=%b exp=1100", {tx0, rdy0, busy0, done0}); end
      vecs++; if ({tx1, rdy1, busy1, done1} !== 4'b1100) begin
         errs++; $display("FAIL reset_dut1 got=%b exp=1100", {tx1, rdy1, busy1, done1}); end
      vecs++; if ({tx2, rdy2, busy2, done2} !== 4'b1100) begin
         errs++; $display("FAIL reset_dut2 got=%b exp=1100", {tx2, rdy2, busy2, done2}); end
      rst = 1'b0;
      tick;
   endtask

   task automatic test_frame(input logic [7:0] d, input int inj_at);
      logic [7:0] rx;
      run(0, d, 105, inj_at, 8'hEE, 0);
      for (int k = 1; k <= 105; k++) begin
         vecs++; if (cap_tx[k] !== exp_bit(d, 0, 1'b0, 1, k)) begin
            errs++; $display("FAIL frame_tx d=%h k=%0d got=%b exp=%b", d, k, cap_tx[k], exp_bit(d, 0, 1'b0, 1, k)); end
         vecs++; if (cap_busy[k] !== (k <= 100)) begin
            errs++; $display("FAIL frame_busy d=%h k=%0d got=%b exp=%b", d, k, cap_busy[k], (k <= 100)); end
         vecs++; if (cap_rdy[k] !== (k > 100)) begin
            errs++; $display("FAIL frame_ready d=%h k=%0d got=%b exp=%b", d, k, cap_rdy[k], (k > 100)); end
         vecs++; if (cap_done[k] !== (k == 101)) begin
            errs++; $display("FAIL frame_done d=%h k=%0d got=%b exp=%b", d, k, cap_done[k], (k == 101)); end
      end
      for (int i = 0; i < 8; i++) rx[i] = cap_tx[10*(i+1) + 5];
      vecs++; if (rx !== d) begin
         errs++; $display("FAIL frame_decode got=%h exp=%h", rx, d); end
   endtask

   task automatic test_parity(input int w, input logic podd, input int nstop);
      int len;
      len = (10 + nstop) * 10;
      run(w, 8'h07, len + 5, 0, 8'h00, 0);
      for (int k = 1; k <= len + 5; k++) begin
         vecs++; if (cap_tx[k] !== exp_bit(8'h07, 1, podd, nstop, k)) begin
            errs++; $display("FAIL parity_tx w=%0d k=%0d got=%b exp=%b", w, k, cap_tx[k], exp_bit(8'h07, 1, podd, nstop, k)); end
         vecs++; if (cap_done[k] !== (k == len + 1)) begin
            errs++; $display("FAIL parity_done w=%0d k=%0d got=%b exp=%b", w, k, cap_done[k], (k == len + 1)); end
      end
      vecs++; if (cap_tx[95] !== ~podd) begin
         errs++; $display("FAIL parity_bit w=%0d got=%b exp=%b", w, cap_tx[95], ~podd); end
   endtask

   task automatic test_reset_midframe;
      run(0, 8'h55, 70, 0, 8'h00, 50);
      for (int k = 1; k <= 70; k++) begin
         vecs++; if (cap_tx[k] !== ((k <= 50) ? exp_bit(8'h55, 0, 1'b0, 1, k) : 1'b1)) begin
            errs++; $display("FAIL rstmid_tx k=%0d got=%b", k, cap_tx[k]); end
         vecs++; if (cap_rdy[k] !== (k > 50)) begin
            errs++; $display("FAIL rstmid_ready k=%0d got=%b exp=%b", k, cap_rdy[k], (k > 50)); end
         vecs++; if (cap_done[k] !== 1'b0) begin
            errs++; $display("FAIL rstmid_done k=%0d got=%b exp=0", k, cap_done[k]); end
      end
      test_frame(8'h5A, 0);
   endtask

   task automatic test_back_to_back;
      logic exp_tx;
      sel = 0;
      data = 8'h12;
      start0 = 1'b1;
      tick;
      data = 8'h34;
      for (int k = 1; k <= 205; k++) begin
         cap_tx[k] = tx0; cap_busy[k] = busy0; cap_done[k] = done0;
         tick;
         if (k == 102) start0 = 1'b0;
      end
      for (int k = 1; k <= 205; k++) begin
         exp_tx = (k <= 101) ? exp_bit(8'h12, 0, 1'b0, 1, k) : exp_bit(8'h34, 0, 1'b0, 1, k - 101);
         vecs++; if (cap_tx[k] !== exp_tx) begin
            errs++; $display("FAIL b2b_tx k=%0d got=%b exp=%b", k, cap_tx[k], exp_tx); end
         vecs++; if (cap_busy[k] !== (k != 101 && k <= 201)) begin
            errs++; $display("FAIL b2b_busy k=%0d got=%b exp=%b", k, cap_busy[k], (k != 101 && k <= 201)); end
         vecs++; if (cap_done[k] !== (k == 101 || k == 202)) begin
            errs++; $display("FAIL b2b_done k=%0d got=%b exp=%b", k, cap_done[k], (k == 101 || k == 202)); end
      end
      start0 = 1'b0;
   endtask

   initial begin
      test_reset;
      test_frame(8'h55, 0);
      test_frame(8'hA3, 0);
      test_frame(8'h00, 0);
      test_frame(8'hFF, 0);
      test_parity(1, 1'b0, 2);
      test_parity(2, 1'b1, 1);
      test_frame(8'h55, 40);
      test_reset_midframe;
      test_back_to_back;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
